fp_div_iter: RTL and testbench

- Parametrised, multi-cycle IEEE-754 binary floating-point divider, Q = A / B.
- Successor to the combinational fp16 divider. It generalises exponent and mantissa width: FP16 by default, FP32 with EXP_W=8, MANT_W=23.
- It replaces the single-cycle datapath with a radix-2 restoring iteration behind a START/BUSY/DONE handshake.
- Unlike the previous block, exceptional results raise IEEE flags, subnormal inputs are normalised, and results are rounded round-to-nearest-even.

---
 rtl/fp_div_iter_if.sv | 21 ++
 rtl/fp_div_iter.sv | 242 ++++++++++++++++++++++++
 tb/tb_fp_div_iter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_iter_if.sv
// fp_div_iter_if: request/response bundle for the iterative FP divider.
//   master: drives START, A, B; observes BUSY, DONE, Q, FLAGS
//   slave : the divider side of the same signals
// Q/FLAGS are W bits / 5 bits with W = 1 + EXP_W + MANT_W.
interface fp_div_iter_if #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
);
  localparam int W = 1 + EXP_W + MANT_W;

  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] Q;
  logic [4:0]   FLAGS;

  modport master (output START, A, B, input BUSY, DONE, Q, FLAGS);
  modport slave  (input START, A, B, output BUSY, DONE, Q, FLAGS);
endinterface

// File: rtl/fp_div_iter.sv
// fp_div_iter: multi-cycle IEEE-754 divider Q = A / B, radix-2 restoring.
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus.START request, sampled only while idle
//   bus.A/B   dividend / divisor {sign, exp, frac}
//   bus.BUSY  high from the cycle after acceptance until DONE
//   bus.DONE  one-cycle pulse, Q/FLAGS valid from this cycle
//   bus.Q     quotient, held until the next DONE
//   bus.FLAGS {invalid, div-by-zero, overflow, underflow, inexact}
// Subnormal inputs are normalised, results are rounded to nearest-even,
// results below the normal range flush to signed zero.
module fp_div_iter #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  fp_div_iter_if.slave   bus
);
  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int M  = MANT_W + 1;   // significand incl. hidden bit
  localparam int N  = MANT_W + 3;   // quotient bits: int, frac, guard, extra
  localparam int EW = EXP_W + 2;    // signed working exponent
  localparam int CW = $clog2(N);
  localparam logic signed [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, FIN} state_t;

  typedef struct packed {
    logic                  is_zero;
    logic                  is_inf;
    logic                  is_nan;
    logic [M-1:0]          mant;
    logic signed [EW-1:0]  exp;
  } opnd_t;

  // Classify an operand (sign stripped) and normalise subnormals so the
  // significand always carries a leading one.
  function automatic opnd_t unpack(input logic [W-2:0] x);
    opnd_t            o;
    logic [EXP_W-1:0] e;
    logic [MANT_W-1:0] f;
    int               p;
    o = '0;
    e = x[MANT_W +: EXP_W];
    f = x[MANT_W-1:0];
    o.is_zero = (e == '0) && (f == '0);
    o.is_inf  = (e == '1) && (f == '0);
    o.is_nan  = (e == '1) && (f != '0);
    if (e == '0) begin
      p = 0;
      for (int i = 0; i < MANT_W; i++)
        if (f[i]) p = i;
      o.mant = M'({1'b0, f} << (MANT_W - p));
      o.exp  = EW'(1 - (MANT_W - p));
    end else begin
      o.mant = {1'b1, f};
      o.exp  = {2'b00, e};
    end
    return o;
  endfunction

  state_t state, state_nx;

  logic [W-1:0]          a_r, b_r;
  logic                  sign_r;
  logic signed [EW-1:0]  exp_r;
  logic [M:0]            rem_r;
  logic [M-1:0]          dvs_r;
  logic [N-1:0]          quo_r;
  logic [CW-1:0]         cnt_r;
  logic [W-1:0]          res_r;
  logic [4:0]            rflg_r;
  logic [W-1:0]          q_r;
  logic [4:0]            flags_r;
  logic                  busy_r, done_r;

  // ---------------- unpack / exception decode ----------------
  opnd_t        ua, ub;
  logic         sgn;
  logic         exc;
  logic [W-1:0] exc_q;
  logic [4:0]   exc_f;

  assign ua  = unpack(a_r[W-2:0]);
  assign ub  = unpack(b_r[W-2:0]);
  assign sgn = a_r[W-1] ^ b_r[W-1];

  always_comb begin
    exc   = 1'b0;
    exc_q = '0;
    exc_f = '0;
    if (ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) ||
        (ua.is_inf && ub.is_inf)) begin
      exc   = 1'b1;
      exc_q = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
      exc_f = 5'b10000;
    end else if (ub.is_zero) begin
      exc   = 1'b1;
      exc_q = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      exc_f = 5'b01000;
    end else if (ua.is_inf) begin
      exc   = 1'b1;
      exc_q = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (ub.is_inf || ua.is_zero) begin
      exc   = 1'b1;
      exc_q = {sgn, {(W-1){1'b0}}};
    end
  end

  // ---------------- restoring divide step ----------------
  logic [M+1:0] trial;
  logic         qbit;
  logic [M:0]   rem_nx;

  always_comb begin
    trial  = {1'b0, rem_r} - {2'b00, dvs_r};
    qbit   = ~trial[M+1];
    rem_nx = qbit ? trial[M:0] : rem_r;
  end

  // ---------------- normalise + round ----------------
  logic [MANT_W-1:0]    rnd_mant, rnd_frac;
  logic                 rnd_g, rnd_s, rnd_up, rnd_ix;
  logic signed [EW-1:0] rnd_e;
  logic [W-1:0]         rnd_q;
  logic [4:0]           rnd_f;

  always_comb begin
    // Quotient is in (0.5, 2). With the integer bit set the lowest quotient
    // bit sits below guard and folds into sticky.
    if (quo_r[N-1]) begin
      rnd_mant = quo_r[N-2:2];
      rnd_g    = quo_r[1];
      rnd_s    = quo_r[0] | (|rem_r);
      rnd_e    = exp_r;
    end else begin
      rnd_mant = quo_r[N-3:1];
      rnd_g    = quo_r[0];
      rnd_s    = |rem_r;
      rnd_e    = exp_r - EW'(1);
    end
    rnd_up   = rnd_g & (rnd_s | rnd_mant[0]);
    // Fraction wraps to zero exactly when rounding carries out of 1.111..1.
    rnd_frac = rnd_mant + MANT_W'(rnd_up);
    if (rnd_up && (&rnd_mant)) rnd_e = rnd_e + EW'(1);
    rnd_ix   = rnd_g | rnd_s;
    if (rnd_e >= EMAX) begin
      rnd_q = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      rnd_f = 5'b00101;
    end else if (rnd_e <= 0) begin
      rnd_q = {sign_r, {(W-1){1'b0}}};
      rnd_f = 5'b00011;
    end else begin
      rnd_q = {sign_r, rnd_e[EXP_W-1:0], rnd_frac};
      rnd_f = {4'b0000, rnd_ix};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.START) state_nx = UNPACK;
      UNPACK:  state_nx = exc ? FIN : DIVIDE;
      DIVIDE:  if (cnt_r == '0) state_nx = ROUND;
      ROUND:   state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sign_r  <= 1'b0;
      exp_r   <= '0;
      rem_r   <= '0;
      dvs_r   <= '0;
      quo_r   <= '0;
      cnt_r   <= '0;
      res_r   <= '0;
      rflg_r  <= '0;
      q_r     <= '0;
      flags_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            a_r    <= bus.A;
            b_r    <= bus.B;
            busy_r <= 1'b1;
          end
        end
        UNPACK: begin
          sign_r <= sgn;
          exp_r  <= ua.exp - ub.exp + BIAS;
          rem_r  <= {1'b0, ua.mant};
          dvs_r  <= ub.mant;
          quo_r  <= '0;
          cnt_r  <= CW'(N - 1);
          if (exc) begin
            res_r  <= exc_q;
            rflg_r <= exc_f;
          end
        end
        DIVIDE: begin
          rem_r <= rem_nx << 1;
          quo_r <= {quo_r[N-2:0], qbit};
          cnt_r <= cnt_r - 1'b1;
        end
        ROUND: begin
          res_r  <= rnd_q;
          rflg_r <= rnd_f;
        end
        FIN: begin
          q_r     <= res_r;
          flags_r <= rflg_r;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY  = busy_r;
  assign bus.DONE  = done_r;
  assign bus.Q     = q_r;
  assign bus.FLAGS = flags_r;
endmodule

// File: tb/tb_fp_div_iter.sv
module tb_fp_div_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fp_div_iter_if #(.EXP_W(5), .MANT_W(10)) b16 ();
  fp_div_iter_if #(.EXP_W(8), .MANT_W(23)) b32 ();

  fp_div_iter #(.EXP_W(5), .MANT_W(10)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  fp_div_iter #(.EXP_W(8), .MANT_W(23)) dut32 (.clk(clk), .rst(rst), .bus(b32));

  typedef struct {
    logic [31:0] q;
    logic [4:0]  f;
    bit          exc;
  } res_t;

  // Reference: exact integer quotient with generous extra precision, then
  // normalise and round to nearest-even.
  function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b, input bit w);
    res_t   r;
    int     ew, mw, p, sh;
    longint emax, fm, bias, sgbit, ea, eb, fa, fb, ma, mb, q, rem, kept, lost, half, e;
    bit     a_nan, b_nan, a_z, b_z, a_i, b_i, up, inex;
    ew    = w ? 8 : 5;
    mw    = w ? 23 : 10;
    emax  = (64'sd1 <<< ew) - 1;
    fm    = (64'sd1 <<< mw) - 1;
    bias  = (64'sd1 <<< (ew - 1)) - 1;
    sgbit = (a[ew+mw] ^ b[ew+mw]) ? (64'sd1 <<< (ew + mw)) : 64'sd0;
    ea = longint'(a >> mw) & emax;  fa = longint'(a) & fm;
    eb = longint'(b >> mw) & emax;  fb = longint'(b) & fm;
    a_nan = (ea == emax) && (fa != 0);  b_nan = (eb == emax) && (fb != 0);
    a_i   = (ea == emax) && (fa == 0);  b_i   = (eb == emax) && (fb == 0);
    a_z   = (ea == 0) && (fa == 0);     b_z   = (eb == 0) && (fb == 0);
    r.exc = 1'b1;
    r.f   = 5'h00;
    r.q   = '0;
    if (a_nan || b_nan || (a_z && b_z) || (a_i && b_i)) begin
      r.q = 32'((emax <<< mw) | (64'sd1 <<< (mw - 1)));
      r.f = 5'h10;
    end else if (b_z) begin
      r.q = 32'(sgbit | (emax <<< mw));
      r.f = 5'h08;
    end else if (a_i) begin
      r.q = 32'(sgbit | (emax <<< mw));
    end else if (b_i || a_z) begin
      r.q = 32'(sgbit);
    end else begin
      r.exc = 1'b0;
      if (ea == 0) begin
        ma = fa; ea = 1;
        while (ma < (64'sd1 <<< mw)) begin ma = ma <<< 1; ea = ea - 1; end
      end else ma = fa | (64'sd1 <<< mw);
      if (eb == 0) begin
        mb = fb; eb = 1;
        while (mb < (64'sd1 <<< mw)) begin mb = mb <<< 1; eb = eb - 1; end
      end else mb = fb | (64'sd1 <<< mw);
      p   = mw + 8;
      q   = (ma <<< p) / mb;
      rem = (ma <<< p) % mb;
      sh  = 0;
      while ((q >>> sh) >= (64'sd1 <<< (mw + 1))) sh++;
      kept = q >>> sh;
      lost = q & ((64'sd1 <<< sh) - 1);
      half = 64'sd1 <<< (sh - 1);
      e    = ea - eb + bias + sh - p + mw;
      up   = (lost > half) || ((lost == half) && ((rem != 0) || ((kept & 1) != 0)));
      inex = (lost != 0) || (rem != 0);
      if (up) kept = kept + 1;
      if (kept == (64'sd1 <<< (mw + 1))) begin kept = kept >>> 1; e = e + 1; end
      if (e >= emax) begin
        r.q = 32'(sgbit | (emax <<< mw));
        r.f = 5'h05;
      end else if (e <= 0) begin
        r.q = 32'(sgbit);
        r.f = 5'h03;
      end else begin
        r.q = 32'(sgbit | (e <<< mw) | (kept & fm));
        r.f = {4'h0, inex};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op(input bit w);
    int     ew, mw, k;
    longint x, em, fm, bias;
    ew   = w ? 8 : 5;
    mw   = w ? 23 : 10;
    bias = (64'sd1 <<< (ew - 1)) - 1;
    x    = longint'($urandom());
    if (!w) x = x & 64'hFFFF;
    em   = ((64'sd1 <<< ew) - 1) <<< mw;
    fm   = (64'sd1 <<< mw) - 1;
    k    = $urandom_range(0, 9);
    case (k)
      0: x = x & ~em;
      1: x = x | em;
      2: x = x & ~fm;
      3, 4, 5, 6: x = (x & ~em) | ((bias + longint'($urandom_range(0, 8)) - 4) <<< mw);
      default: ;
    endcase
    return 32'(x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] b, input logic st);
    if (w) begin b32.A = a;       b32.B = b;       b32.START = st; end
    else   begin b16.A = a[15:0]; b16.B = b[15:0]; b16.START = st; end
  endtask

  function automatic logic get_done(input bit w);
    return w ? b32.DONE : b16.DONE;
  endfunction
  function automatic logic get_busy(input bit w);
    return w ? b32.BUSY : b16.BUSY;
  endfunction
  function automatic logic [31:0] get_q(input bit w);
    return w ? b32.Q : {16'h0000, b16.Q};
  endfunction
  function automatic logic [31:0] get_f(input bit w);
    return w ? {27'd0, b32.FLAGS} : {27'd0, b16.FLAGS};
  endfunction

  // One transaction: START sampled at edge 0, DONE expected after edge elat.
  task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [4:0] ef, input int elat,
                       input string tag);
    int lat;
    bit busy_ok;
    @(negedge clk); drive(w, a, b, 1'b1);
    @(posedge clk); #1; drive(w, a, b, 1'b0);
    busy_ok = get_busy(w);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (get_done(w)) begin lat = k; break; end
      if (!get_busy(w)) busy_ok = 1'b0;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " q"}, get_q(w), eq);
    chk({tag, " flags"}, get_f(w), {27'd0, ef});
    chk({tag, " busy at done"}, {31'd0, get_busy(w)}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, {31'd0, get_done(w)}, 32'd0);
  endtask

  task automatic rnd_run(input bit w);
    logic [31:0] a, b;
    res_t r;
    a = rnd_op(w);
    b = rnd_op(w);
    r = ref_div(a, b, w);
    do_op(w, a, b, r.q, r.f, r.exc ? 2 : (w ? 29 : 16), w ? "rnd32" : "rnd16");
  endtask

  initial begin
    int ndone, lat;
    drive(0, 0, 0, 1'b0);
    drive(1, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy16", {31'd0, b16.BUSY}, 0);
    chk("rst done16", {31'd0, b16.DONE}, 0);
    chk("rst q16",    get_q(0), 0);
    chk("rst flags16", get_f(0), 0);
    chk("rst busy32", {31'd0, b32.BUSY}, 0);
    chk("rst q32",    get_q(1), 0);
    @(negedge clk); rst = 1'b0;

    do_op(0, 32'h4600, 32'h4000, 32'h4200, 5'h00, 16, "6/2");
    do_op(0, 32'h3C00, 32'h4200, 32'h3555, 5'h01, 16, "1/3");
    do_op(0, 32'h0200, 32'h3800, 32'h0400, 5'h00, 16, "subnorm");
    do_op(0, 32'h3C00, 32'h0000, 32'h7C00, 5'h08, 2,  "x/0");
    do_op(0, 32'h0000, 32'h0000, 32'h7E00, 5'h10, 2,  "0/0");
    do_op(0, 32'hFC00, 32'h4000, 32'hFC00, 5'h00, 2,  "-inf/2");
    do_op(0, 32'h7BFF, 32'h3800, 32'h7C00, 5'h05, 16, "ovf");
    do_op(0, 32'h0400, 32'h4000, 32'h0000, 5'h03, 16, "unf");
    do_op(1, 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 29, "f32 6/2");
    do_op(1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 29, "f32 1/3");

    // START while busy is ignored
    @(negedge clk); drive(0, 32'h4600, 32'h4000, 1'b1);
    @(posedge clk); #1; drive(0, 32'h4600, 32'h4000, 1'b0);
    ndone = 0; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) drive(0, 32'h3C00, 32'h0000, 1'b1);
      @(posedge clk); #1;
      if (k == 5) drive(0, 32'h3C00, 32'h0000, 1'b0);
      if (b16.DONE) begin ndone++; if (lat == 0) lat = k; end
    end
    chk("busy start ndone", ndone, 1);
    chk("busy start lat", lat, 16);
    chk("busy start q", get_q(0), 32'h4200);
    chk("busy start flags", get_f(0), 0);

    // Reset in the middle of an operation
    @(negedge clk); drive(0, 32'h3C00, 32'h4200, 1'b1);
    @(posedge clk); #1; drive(0, 32'h3C00, 32'h4200, 1'b0);
    repeat (8) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("midrst busy", {31'd0, b16.BUSY}, 0);
    chk("midrst done", {31'd0, b16.DONE}, 0);
    chk("midrst q", get_q(0), 0);
    chk("midrst flags", get_f(0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (b16.DONE) ndone++;
    end
    chk("midrst no done", ndone, 0);
    chk("midrst q held", get_q(0), 0);
    do_op(0, 32'h4600, 32'h4000, 32'h4200, 5'h00, 16, "post rst");

    for (int i = 0; i < 40; i++) rnd_run(0);
    for (int i = 0; i < 15; i++) rnd_run(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
